// File: rtl/axis_write_packer.sv
// rtl/axis_write_packer.sv - packs stream words into AXI W beats with strobes, bursts and a command queue
module axis_write_packer #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int CFG_QAWIDTH    = 2,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CFG_DWIDTH-1:0]       cfg_length,
  input  logic                        cfg_val,
  output logic                        cfg_rdy,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        busy
);
  localparam int RATIO  = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int WBYTES = DATA_WIDTH / 8;
  localparam int ENT_W  = AXI_DATA_WIDTH + STRB_W + 1;
  localparam logic [CFG_QAWIDTH:0] Q_FULL   = (CFG_QAWIDTH+1)'(1 << CFG_QAWIDTH);
  localparam logic [BUF_AWIDTH:0]  F_FULL   = (BUF_AWIDTH+1)'(1 << BUF_AWIDTH);
  localparam logic [LANE_W-1:0]    LANE_MAX = LANE_W'(RATIO - 1);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [CFG_DWIDTH-1:0]     q_mem [1 << CFG_QAWIDTH];
  logic [CFG_QAWIDTH-1:0]    q_wr, q_rd;
  logic [CFG_QAWIDTH:0]      q_cnt;
  logic                      q_push, q_pop;
  logic [CFG_DWIDTH-1:0]     q_head;

  logic [ENT_W-1:0]          f_mem [1 << BUF_AWIDTH];
  logic [BUF_AWIDTH-1:0]     f_wr, f_rd;
  logic [BUF_AWIDTH:0]       f_cnt;
  logic                      f_full, f_pop;
  logic [ENT_W-1:0]          f_head;

  logic [0:0]                state;
  logic [CFG_DWIDTH-1:0]     remaining;
  logic [LANE_W-1:0]         lane;
  logic [AXI_LEN_WIDTH-1:0]  bcnt;
  logic [AXI_DATA_WIDTH-1:0] pack, merged;
  logic [STRB_W-1:0]         strb;
  logic                      acc, last_word, beat_push, push_last;

  assign q_head  = q_mem[q_rd];
  assign cfg_rdy = !rst && (q_cnt != Q_FULL);
  assign q_push  = cfg_val && cfg_rdy;
  assign q_pop   = (state == S_IDLE) && (q_cnt != '0);

  assign f_full     = (f_cnt == F_FULL);
  assign axi_wvalid = (f_cnt != '0);
  assign f_pop      = axi_wvalid && axi_wready;
  assign f_head     = f_mem[f_rd];
  // Gate the head so an empty FIFO shows zeros rather than stale memory.
  assign axi_wdata  = axi_wvalid ? f_head[ENT_W-1 -: AXI_DATA_WIDTH] : '0;
  assign axi_wstrb  = axi_wvalid ? f_head[STRB_W:1] : '0;
  assign axi_wlast  = axi_wvalid && f_head[0];

  assign ready     = (state == S_ACTIVE) && !f_full;
  assign acc       = valid && ready;
  assign last_word = (remaining == CFG_DWIDTH'(1));
  assign beat_push = acc && ((lane == LANE_MAX) || last_word);
  assign push_last = (bcnt == '1) || last_word;
  assign busy      = (q_cnt != '0) || (state == S_ACTIVE) || (f_cnt != '0);

  // Lanes above the current one are still zero in pack, so strobes follow lane.
  always_comb begin
    merged = pack;
    strb   = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) == lane) merged[i*DATA_WIDTH +: DATA_WIDTH] = data;
      if (LANE_W'(i) <= lane) strb[i*WBYTES +: WBYTES] = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr] <= cfg_length;
    if (beat_push) f_mem[f_wr] <= {merged, strb, push_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
      f_wr  <= '0;
      f_rd  <= '0;
      f_cnt <= '0;
    end else begin
      if (q_push) q_wr <= q_wr + CFG_QAWIDTH'(1);
      if (q_pop)  q_rd <= q_rd + CFG_QAWIDTH'(1);
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + (CFG_QAWIDTH+1)'(1);
        2'b01:   q_cnt <= q_cnt - (CFG_QAWIDTH+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
      if (beat_push) f_wr <= f_wr + BUF_AWIDTH'(1);
      if (f_pop)     f_rd <= f_rd + BUF_AWIDTH'(1);
      case ({beat_push, f_pop})
        2'b10:   f_cnt <= f_cnt + (BUF_AWIDTH+1)'(1);
        2'b01:   f_cnt <= f_cnt - (BUF_AWIDTH+1)'(1);
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      lane      <= '0;
      bcnt      <= '0;
      pack      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Zero-length commands are popped here and never leave IDLE.
          if (q_pop && (q_head != '0)) begin
            state     <= S_ACTIVE;
            remaining <= q_head;
            lane      <= '0;
            bcnt      <= '0;
            pack      <= '0;
          end
        end
        default: begin
          if (acc) begin
            remaining <= remaining - CFG_DWIDTH'(1);
            if (beat_push) begin
              pack <= '0;
              lane <= '0;
              bcnt <= bcnt + AXI_LEN_WIDTH'(1);
            end else begin
              pack <= merged;
              lane <= lane + LANE_W'(1);
            end
            if (last_word) state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_write_packer.sv
// tb/tb_axis_write_packer.sv - self-checking bench for axis_write_packer
module tb_axis_write_packer;
  localparam int R    = 2;
  localparam int DW   = 32;
  localparam int ADW  = 64;
  localparam int MAXB = 16;

  typedef struct packed {
    logic [ADW-1:0]   d;
    logic [ADW/8-1:0] s;
    logic             l;
  } beat_t;

  typedef struct {
    int         len;
    int         base;
    int         exp_beats;
    logic [7:0] exp_strb;
    int         exp_lasts;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [31:0]     cfg_length;
  logic            cfg_val;
  logic            cfg_rdy;
  logic [ADW-1:0]  axi_wdata;
  logic [ADW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [DW-1:0]   data;
  logic            valid;
  logic            ready;
  logic            busy;

  axis_write_packer dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .data(data), .valid(valid), .ready(ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      total = 0;
  int      bad = 0;
  int      cq[$];
  logic [31:0] wq[$];
  beat_t   eq[$];
  int      p_cfg = 100, p_valid = 100, p_wready = 100;
  bit      toggle = 0;
  int      words_acc, cmds_acc, beats_seen, lasts_seen;
  logic [7:0] last_strb_seen;
  bit      held_v = 0;
  beat_t   held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    words_acc = 0; cmds_acc = 0; beats_seen = 0; lasts_seen = 0; last_strb_seen = 0;
  endtask

  // Reference: beats are the words grouped R at a time, bursts of MAXB beats.
  task automatic add_xfer(input int len, input int base);
    logic [31:0] w[$];
    beat_t b;
    int nb;
    cq.push_back(len);
    for (int i = 0; i < len; i++) begin
      w.push_back(base == 0 ? 32'($urandom) : 32'(base + i));
      wq.push_back(w[i]);
    end
    nb = (len + R - 1) / R;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int k = 0; k < R; k++) begin
        if (bi * R + k < len) begin
          b.d[k*DW +: DW] = w[bi*R + k];
          b.s[k*(DW/8) +: DW/8] = '1;
        end
      end
      b.l = ((bi % MAXB) == MAXB - 1) || (bi == nb - 1);
      eq.push_back(b);
    end
  endtask

  task automatic check_beat();
    beat_t b;
    beats_seen++;
    last_strb_seen = axi_wstrb;
    if (axi_wlast) lasts_seen++;
    if (eq.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_beat act=%h exp=none", axi_wdata);
    end else begin
      b = eq.pop_front();
      chk("wdata", axi_wdata, b.d);
      chk("wstrb", 64'(axi_wstrb), 64'(b.s));
      chk("wlast", 64'(axi_wlast), 64'(b.l));
    end
  endtask

  // Called at a falling edge: drive, account handshakes for the next rising edge, advance.
  task automatic step();
    cfg_val    = (cq.size() > 0) && ($urandom_range(99) < p_cfg);
    cfg_length = (cq.size() > 0) ? 32'(cq[0]) : 32'd0;
    valid      = (wq.size() > 0) && ($urandom_range(99) < p_valid);
    data       = (wq.size() > 0) ? wq[0] : 32'd0;
    if (toggle) axi_wready = ~axi_wready;
    else        axi_wready = ($urandom_range(99) < p_wready);
    if (rst) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 64'(axi_wvalid), 64'd1);
        chk("stall_stable", 64'({axi_wdata, axi_wstrb, axi_wlast} != held), 64'd0);
      end
      held_v = axi_wvalid && !axi_wready;
      held   = {axi_wdata, axi_wstrb, axi_wlast};
      if (cfg_val && cfg_rdy) begin void'(cq.pop_front()); cmds_acc++; end
      if (valid && ready) begin void'(wq.pop_front()); words_acc++; end
      if (axi_wvalid && axi_wready) check_beat();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((cq.size() > 0 || wq.size() > 0 || eq.size() > 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk("drain_in_time", 64'(n < max), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_rdy"}, 64'(cfg_rdy), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_wvalid"}, 64'(axi_wvalid), 64'd0);
    chk({tag, "_wlast"}, 64'(axi_wlast), 64'd0);
    chk({tag, "_wdata"}, axi_wdata, 64'd0);
    chk({tag, "_wstrb"}, 64'(axi_wstrb), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t tbl[8];
    int n, exp_beats;

    rst = 1; cfg_val = 0; cfg_length = 0; valid = 0; data = 0; axi_wready = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 0;
    @(negedge clk);
    chk("cfg_rdy_after_reset", 64'(cfg_rdy), 64'd1);

    // Basic packing with command-to-ready timing
    clr_cnt();
    p_cfg = 100; p_valid = 0; p_wready = 100;
    add_xfer(8, 1);
    step();
    chk("busy_after_cmd", 64'(busy), 64'd1);
    chk("ready_after_E", 64'(ready), 64'd0);
    step();
    chk("ready_after_E1", 64'(ready), 64'd1);
    p_valid = 100;
    run_until_idle(100);
    chk("basic_beats", 64'(beats_seen), 64'd4);
    chk("basic_lasts", 64'(lasts_seen), 64'd1);
    chk("basic_busy", 64'(busy), 64'd0);

    tbl[0] = '{8, 1, 4, 8'hFF, 1};
    tbl[1] = '{5, 1, 3, 8'h0F, 1};
    tbl[2] = '{1, 0, 1, 8'h0F, 1};
    tbl[3] = '{2, 0, 1, 8'hFF, 1};
    tbl[4] = '{33, 0, 17, 8'h0F, 2};
    tbl[5] = '{32, 0, 16, 8'hFF, 1};
    tbl[6] = '{0, 0, 0, 8'h00, 0};
    tbl[7] = '{34, 0, 17, 8'hFF, 2};
    for (int t = 0; t < 8; t++) begin
      clr_cnt();
      add_xfer(tbl[t].len, tbl[t].base);
      run_until_idle(200);
      chk($sformatf("tbl%0d_beats", t), 64'(beats_seen), 64'(tbl[t].exp_beats));
      chk($sformatf("tbl%0d_strb", t), 64'(last_strb_seen), 64'(tbl[t].exp_strb));
      chk($sformatf("tbl%0d_lasts", t), 64'(lasts_seen), 64'(tbl[t].exp_lasts));
      chk($sformatf("tbl%0d_idle_ready", t), 64'(ready), 64'd0);
    end

    // Backpressure then toggled wready
    clr_cnt();
    p_wready = 0;
    add_xfer(8, 0);
    run_n(12);
    chk("bp_words", 64'(words_acc), 64'd8);
    chk("bp_beats_held", 64'(beats_seen), 64'd0);
    chk("bp_wvalid", 64'(axi_wvalid), 64'd1);
    toggle = 1;
    run_until_idle(100);
    toggle = 0;
    chk("bp_beats", 64'(beats_seen), 64'd4);

    // Multi-burst with queued single-word commands
    clr_cnt();
    p_wready = 100;
    add_xfer(4092, 0);
    add_xfer(1, 0);
    add_xfer(1, 0);
    run_until_idle(6000);
    chk("mb_beats", 64'(beats_seen), 64'd2048);
    chk("mb_lasts", 64'(lasts_seen), 64'd130);

    // FIFO fill, queue fill and zero-length command
    clr_cnt();
    p_wready = 0;
    add_xfer(64, 0);
    run_n(50);
    chk("fill_words", 64'(words_acc), 64'd32);
    chk("fill_ready", 64'(ready), 64'd0);
    add_xfer(1, 0);
    add_xfer(2, 0);
    add_xfer(0, 0);
    add_xfer(3, 0);
    run_n(10);
    chk("qfill_cmds", 64'(cmds_acc), 64'd5);
    chk("qfill_cfg_rdy", 64'(cfg_rdy), 64'd0);
    add_xfer(5, 0);
    run_n(5);
    chk("qfull_blocked", 64'(cmds_acc), 64'd5);
    p_wready = 100;
    run_until_idle(500);
    chk("fill_beats", 64'(beats_seen), 64'd39);

    // Reset in the middle of a transfer
    clr_cnt();
    add_xfer(8, 0);
    add_xfer(4, 0);
    n = 0;
    while (words_acc < 3 && n < 50) begin step(); n++; end
    chk("rst_setup_in_time", 64'(n < 50), 64'd1);
    cq.delete(); wq.delete(); eq.delete();
    rst = 1;
    step();
    chk_reset_outputs("midrst");
    rst = 0;
    run_n(5);
    chk("post_rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("post_rst_ready", 64'(ready), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    clr_cnt();
    add_xfer(2, 'hA);
    run_until_idle(50);
    chk("post_rst_beats", 64'(beats_seen), 64'd1);

    // Randomized commands and handshake rates
    clr_cnt();
    exp_beats = 0;
    p_cfg = $urandom_range(20, 100);
    p_valid = $urandom_range(30, 100);
    p_wready = $urandom_range(30, 100);
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 40);
      exp_beats += (n + R - 1) / R;
      add_xfer(n, 0);
    end
    run_until_idle(20000);
    chk("rand_beats", 64'(beats_seen), 64'(exp_beats));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_write_packer.md
# axis_write_packer

Write-data engine for an AXI stream-to-memory writer. It accepts queued transfer commands, each a length in stream words. It packs narrow stream words into AXI write beats with byte strobes, splits each transfer into bursts, and drives the AXI W channel through an internal beat FIFO. It is a generalisation of the single-command write-data path: any power-of-two width ratio, a command queue, partial-beat strobes and an idle/busy indication.

## Interface
- BUF_AWIDTH, 4: beat FIFO depth is 2^BUF_AWIDTH AXI beats.
- CFG_DWIDTH, 32: width of cfg_length and of the remaining-word counter.
- CFG_QAWIDTH, 2: command queue depth is 2^CFG_QAWIDTH entries.
- AXI_LEN_WIDTH, 4: maximum burst length is MAXB = 2^AXI_LEN_WIDTH beats.
- AXI_DATA_WIDTH, 64: AXI W data width; must be a multiple of 8.
- DATA_WIDTH, 32: stream word width. RATIO = AXI_DATA_WIDTH/DATA_WIDTH must be a power of two ≥1, and DATA_WIDTH must be a multiple of 8.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_length  in  CFG_DWIDTH  transfer length in stream words.
- cfg_val  in  1  command valid.
- cfg_rdy  out  1  command queue not full.
- axi_wdata  out  AXI_DATA_WIDTH  beat data.
- axi_wstrb  out  AXI_DATA_WIDTH/8  byte strobes.
- axi_wlast  out  1  last beat of a burst.
- axi_wvalid  out  1  beat valid.
- axi_wready  in  1  slave ready.
- data  in  DATA_WIDTH  stream word.
- valid  in  1  stream word valid.
- ready  out  1  stream word accepted when valid & ready.
- busy  out  1  queue non-empty, or transfer active, or FIFO non-empty.

## Operation
- **Command queue:** cfg_val & cfg_rdy pushes cfg_length. A length-0 command is popped and discarded without producing any beat.
- **States:** IDLE and ACTIVE.
  - IDLE with the queue non-empty: pop the command, load remaining = length, lane = 0, burst beat count = 0, and go to ACTIVE.
  - ACTIVE: accept words. When the final word is accepted, go to IDLE. This gives exactly one ready=0 bubble cycle between back-to-back transfers.
- **ready** = ACTIVE & FIFO not full. Words beyond a transfer's length are never accepted; they wait for the next command.
- **Packing:** the k-th word of a beat occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. The first word goes in the lowest lane.
- **Beat push:** a beat is pushed to the FIFO when its RATIO-th word or the transfer's final word is accepted. The completing word is merged combinationally, so there is no extra cycle.
- **Partial beat:** unfilled lanes are zero, and their strobe bytes are 0. Full beats carry all-ones strobes.
- **Beat count:** a transfer produces ceil(length/RATIO) beats.
- **Bursts:** beats are grouped into bursts of MAXB, with a shorter final burst for any remainder. wlast is set on beat MAXB-1 of each burst and on the transfer's final beat. wlast is computed at push time and stored in the FIFO with data and strobes.
- **Counters:**
  - Lane counter: log2(RATIO) bits, wraps to 0.
  - Burst beat counter: AXI_LEN_WIDTH bits; wraps to 0 after MAXB-1 and is reset at each transfer start.
  - Remaining counter: CFG_DWIDTH bits, decrements per accepted word; no underflow.
- **AXI output:** the FIFO head drives axi_*. A beat is dequeued on axi_wvalid & axi_wready. axi_wdata, axi_wstrb and axi_wlast are held stable while axi_wvalid & !axi_wready.
- **Reset mid-operation:** the queue, FIFO, packer register and counters are cleared. No partial beat is emitted.

## Timing
- **Reset values:** cfg_rdy=0, ready=0, axi_wvalid=0, axi_wlast=0, axi_wdata=0, axi_wstrb=0, busy=0. cfg_rdy is 1 from the first cycle after rst deasserts.
- **Command to ready:**
  - Command accepted at edge E while idle with an empty queue: state is ACTIVE and ready=1 after edge E+1.
  - busy=1 after edge E.
- **Stream to AXI:** beat-completing word accepted at edge T with the FIFO empty → axi_wvalid=1 in the cycle after edge T.
- **Throughput:** one stream word per cycle. One AXI beat per cycle when axi_wready=1.
- **FIFO full:** ready drops in the cycle after the edge that fills the FIFO. A simultaneous push and pop when one entry is free keeps ready=1.
- **Queue full:** cfg_rdy=0 when 2^CFG_QAWIDTH entries are held. A pop and push in the same cycle is allowed.
- **busy** deasserts in the cycle after the final beat's handshake, provided the queue is empty.

## Test plan
Default parameters (RATIO=2, MAXB=16) unless stated.

1. **Basic packing:** after reset, cfg_length=8, axi_wready=1, words 1..8 → 4 beats 0x00000002_00000001 … 0x00000008_00000007, wstrb=0xFF, wlast only on beat 4, busy then 0.
2. **Backpressure:** cfg_length=8, axi_wready=0 while 8 words are sent → ready stays 1 and 4 beats are held. Then toggle axi_wready every cycle → beats emerge in order with data stable while stalled, no loss or duplication.
3. **Partial beat and idle stall:** cfg_length=5 → beat 3 = 0x00000000_00000005 with wstrb=0x0F and wlast. A 6th word presented afterwards sees ready=0.
4. **Multi-burst and queued commands:**
   - Commands 4092, 1, 1 sent back-to-back, then 4094 words → 2046 beats for the first command, with wlast on every 16th beat and on beat 2046 (final burst is 14 beats).
   - Then two single beats, each with wstrb=0x0F and wlast, with one ready bubble between commands.
5. **Fill and zero-length:**
   - axi_wready=0 with cfg_length=64 → ready drops after word 32 (16 beats).
   - With that transfer stalled, 4 further commands fill the queue; the 5th sees cfg_rdy=0.
   - A cfg_length=0 command produces no beat.
6. **Reset mid-transfer:** rst for 1 cycle after 3 of 8 words → all outputs at reset values and queued commands lost. Then cfg_length=2 with words 0xA, 0xB → a single beat 0x0000000B_0000000A with wlast.
